// File: rtl/seq_detector_param.sv
// ---------------------------------------------------------------------------
// seq_detector_param
// Parametrised serial bit-pattern detector with a run-time reloadable pattern,
// selectable overlapping / non-overlapping detection, a valid-qualified input
// and a saturating match counter.
//
// Parameters:
//   PAT_W    pattern length in bits (2..32)
//   PATTERN  reset value of the pattern register, MSB = first bit received
//   CNT_W    width of the saturating match counter (1..32)
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   in           serial data bit
//   in_valid     qualifies in
//   overlap      1 = overlapping detection, 0 = non-overlapping
//   pat_wr       load pat_in into the pattern register (clears history)
//   pat_in       new pattern value
//   pat_mask     don't-care mask, 1 = bit ignored (only with SEQ_DET_MASK_EN)
//   clr_count    clear match_count (wins over a coincident hit)
//   match        registered one-cycle pulse per detected pattern
//   match_count  saturating number of matches
//
// Build option: define SEQ_DET_MASK_EN to add the pat_mask port; without it
// every pattern bit is compared exactly.
// ---------------------------------------------------------------------------
module seq_detector_param #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in,
    input  logic             in_valid,
    input  logic             overlap,
    input  logic             pat_wr,
    input  logic [PAT_W-1:0] pat_in,
`ifdef SEQ_DET_MASK_EN
    input  logic [PAT_W-1:0] pat_mask,
`endif
    input  logic             clr_count,
    output logic             match,
    output logic [CNT_W-1:0] match_count
);

    localparam int               FILL_W   = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0] FILL_THR = FILL_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    logic [PAT_W-1:0]  hist_q,    hist_d;
    logic [FILL_W-1:0] fill_q,    fill_d;
    logic [PAT_W-1:0]  pattern_q, pattern_d;
    logic              match_q,   match_d;
    logic [CNT_W-1:0]  count_q,   count_d;

    logic              accept;
    logic [PAT_W-1:0]  hist_shift;
    logic [PAT_W-1:0]  care_n;
    logic [PAT_W-1:0]  bit_eq;
    logic              hit;

`ifdef SEQ_DET_MASK_EN
    assign care_n = pat_mask;
`else
    assign care_n = '0;
`endif

    // A pattern write takes the cycle, so the data bit is not accepted then.
    assign accept     = in_valid && !pat_wr;
    assign hist_shift = {hist_q[PAT_W-2:0], in};

    // Per-bit compare against the history as it will look after this bit.
    generate
        for (genvar gi = 0; gi < PAT_W; gi++) begin : g_cmp
            assign bit_eq[gi] = (hist_shift[gi] == pattern_q[gi]) || care_n[gi];
        end
    endgenerate

    // fill_q counts bits already held; the incoming bit completes the window
    // once fill_q has reached PAT_W-1.
    assign hit = accept && (fill_q >= FILL_THR) && (&bit_eq);

    always_comb begin
        hist_d    = hist_q;
        fill_d    = fill_q;
        pattern_d = pattern_q;
        match_d   = hit;
        count_d   = count_q;

        if (pat_wr) begin
            pattern_d = pat_in;
            hist_d    = '0;
            fill_d    = '0;
        end else if (accept) begin
            hist_d = hist_shift;
            if (hit && !overlap) begin
                fill_d = '0;
            end else if (fill_q != FILL_MAX) begin
                fill_d = fill_q + FILL_W'(1);
            end
        end

        if (clr_count) begin
            count_d = '0;
        end else if (hit && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q    <= '0;
            fill_q    <= '0;
            pattern_q <= PATTERN;
            match_q   <= 1'b0;
            count_q   <= '0;
        end else begin
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            pattern_q <= pattern_d;
            match_q   <= match_d;
            count_q   <= count_d;
        end
    end

    assign match       = match_q;
    assign match_count = count_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// ---------------------------------------------------------------------------
// tb_seq_detector_param
// Directed bench: a table of per-cycle stimulus with expected outputs for the
// default 4-bit instance, plus hand-written sequences for counter saturation
// on a 2-bit / CNT_W=2 instance and (when built with SEQ_DET_MASK_EN) masking.
// ---------------------------------------------------------------------------
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in = 1'b0;
    logic       in_valid = 1'b0;
    logic       overlap = 1'b1;
    logic       pat_wr = 1'b0;
    logic [3:0] pat_in = 4'b0000;
    logic       clr_count = 1'b0;
    logic       match_a;
    logic [7:0] count_a;

    logic       pat_wr_b = 1'b0;
    logic [1:0] pat_in_b = 2'b00;
    logic       match_b;
    logic [1:0] count_b;

`ifdef SEQ_DET_MASK_EN
    logic [3:0] pat_mask = 4'b0000;
    logic [1:0] pat_mask_b = 2'b00;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_detector_param #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .in(in), .in_valid(in_valid),
        .overlap(overlap), .pat_wr(pat_wr), .pat_in(pat_in),
`ifdef SEQ_DET_MASK_EN
        .pat_mask(pat_mask),
`endif
        .clr_count(clr_count), .match(match_a), .match_count(count_a)
    );

    seq_detector_param #(.PAT_W(2), .PATTERN(2'b11), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .in(in), .in_valid(in_valid),
        .overlap(overlap), .pat_wr(pat_wr_b), .pat_in(pat_in_b),
`ifdef SEQ_DET_MASK_EN
        .pat_mask(pat_mask_b),
`endif
        .clr_count(clr_count), .match(match_b), .match_count(count_b)
    );

    typedef struct {
        logic       rst;
        logic       bit_in;
        logic       vld;
        logic       ovl;
        logic       pw;
        logic [3:0] pin;
        logic       clr;
        logic       exp_match;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic b, input logic vld,
                                input logic ovl, input logic pw, input logic [3:0] pin,
                                input logic clr, input logic em, input logic [7:0] ec);
        vec_t v;
        v.rst = rst; v.bit_in = b; v.vld = vld; v.ovl = ovl; v.pw = pw;
        v.pin = pin; v.clr = clr; v.exp_match = em; v.exp_cnt = ec;
        return v;
    endfunction

    // Drive one cycle of inputs, let the edge happen, sample 1 time unit later.
    task automatic step(input logic rst, input logic b, input logic vld, input logic ovl,
                        input logic pw, input logic [3:0] pin, input logic clr);
        reset = rst; in = b; in_valid = vld; overlap = ovl;
        pat_wr = pw; pat_in = pin; clr_count = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Short-hand for valid data bits on dut_a with given overlap.
    function automatic void bits(input logic ovl, input logic b, input logic em,
                                 input logic [7:0] ec);
        vecs.push_back(mk(1'b0, b, 1'b1, ovl, 1'b0, 4'h0, 1'b0, em, ec));
    endfunction

    function automatic void rst_row();
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 8'd0));
    endfunction

    initial begin
        // ---- table for dut_a ----
        rst_row();
        // overlapping: 1,0,1,1,0,1,1 -> hits on bits 4 and 7
        bits(1, 1, 0, 0); bits(1, 0, 0, 0); bits(1, 1, 0, 0); bits(1, 1, 1, 1);
        bits(1, 0, 0, 1); bits(1, 1, 0, 1); bits(1, 1, 1, 2);
        // clear with no valid data
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 8'd0));
        rst_row();
        // non-overlapping: only bit 4 hits
        bits(0, 1, 0, 0); bits(0, 0, 0, 0); bits(0, 1, 0, 0); bits(0, 1, 1, 1);
        bits(0, 0, 0, 1); bits(0, 1, 0, 1); bits(0, 1, 0, 1);
        rst_row();
        // gap of invalid cycles is transparent
        bits(1, 1, 0, 0); bits(1, 0, 0, 0);
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 8'd0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 8'd0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 8'd0));
        bits(1, 1, 0, 0); bits(1, 1, 1, 1);
        rst_row();
        // pattern reload discards history and ignores the coincident bit
        bits(1, 1, 0, 0); bits(1, 0, 0, 0); bits(1, 1, 0, 0);
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0110, 1'b0, 1'b0, 8'd0));
        bits(1, 0, 0, 0); bits(1, 1, 0, 0); bits(1, 1, 0, 0); bits(1, 0, 1, 1);
        rst_row();
        // reset mid-stream, then reset pattern 1011 is back in force
        bits(1, 1, 0, 0); bits(1, 0, 0, 0); bits(1, 1, 0, 0);
        rst_row();
        bits(1, 1, 0, 0); bits(1, 0, 0, 0); bits(1, 1, 0, 0); bits(1, 1, 1, 1);
        // overlap continues; clear coincident with a hit
        bits(1, 0, 0, 1); bits(1, 1, 0, 1);
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 8'd0));
        bits(1, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].bit_in, vecs[i].vld, vecs[i].ovl,
                 vecs[i].pw, vecs[i].pin, vecs[i].clr);
            $display("vec %0d: rst=%0b in=%0b vld=%0b ovl=%0b pw=%0b clr=%0b -> match=%0b cnt=%0d",
                     i, vecs[i].rst, vecs[i].bit_in, vecs[i].vld, vecs[i].ovl,
                     vecs[i].pw, vecs[i].clr, match_a, count_a);
            chk($sformatf("vec%0d_match", i), 32'(match_a), 32'(vecs[i].exp_match));
            chk($sformatf("vec%0d_count", i), 32'(count_a), 32'(vecs[i].exp_cnt));
        end

        // ---- dut_b: pattern 11, CNT_W=2, saturation ----
        step(1, 0, 0, 1, 0, 4'h0, 0);
        chk("b_reset_match", 32'(match_b), 32'd0);
        chk("b_reset_count", 32'(count_b), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            step(0, 1, 1, 1, 0, 4'h0, 0);
            $display("b bit %0d: match=%0b cnt=%0d", i, match_b, count_b);
            chk($sformatf("b_bit%0d_match", i), 32'(match_b), (i >= 2) ? 32'd1 : 32'd0);
            chk($sformatf("b_bit%0d_count", i), 32'(count_b),
                32'((i - 1 > 3) ? 3 : i - 1));
        end
        step(0, 1, 1, 1, 0, 4'h0, 1);
        $display("b clr+hit: match=%0b cnt=%0d", match_b, count_b);
        chk("b_clr_hit_match", 32'(match_b), 32'd1);
        chk("b_clr_hit_count", 32'(count_b), 32'd0);
        step(0, 1, 1, 1, 0, 4'h0, 0);
        $display("b after clr: match=%0b cnt=%0d", match_b, count_b);
        chk("b_after_clr_count", 32'(count_b), 32'd1);

`ifdef SEQ_DET_MASK_EN
        // ---- dut_a with bit 2 masked: 1111 matches 1011 ----
        step(1, 0, 0, 1, 0, 4'h0, 0);
        pat_mask = 4'b0100;
        for (int i = 1; i <= 4; i++) begin
            step(0, 1, 1, 1, 0, 4'h0, 0);
            $display("mask bit %0d: match=%0b cnt=%0d", i, match_a, count_a);
            chk($sformatf("mask_bit%0d_match", i), 32'(match_a), (i == 4) ? 32'd1 : 32'd0);
        end
        chk("mask_count", 32'(count_a), 32'd1);
        pat_mask = 4'b0000;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
